// File: rtl/serial_word_deserializer_pkg.sv
// serial_word_deserializer_pkg: shared width default, state codes and counter-width helper
package serial_word_deserializer_pkg;
  localparam int WIDTH_DEF = 16;
  typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_RECEIVE = 2'b01} state_e;
  function automatic int cw(input int w);
    return $clog2(w);
  endfunction
endpackage

// File: rtl/deser_shift_register.sv
// deser_shift_register: shift register that assembles the serial word in either bit order
module deser_shift_register
  import serial_word_deserializer_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             din,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] base, q_d;
  // clear together with shift_en makes din the first bit of a fresh word
  assign base = clear ? '0 : q;
  always_comb q_d = shift_en ? (MSB_FIRST ? {base[WIDTH-2:0], din} : {din, base[WIDTH-1:1]}) : base;
  always_ff @(posedge clock)
    q <= resetn ? q_d : '0;
endmodule

// File: rtl/serial_word_deserializer.sv
// serial_word_deserializer: rebuilds framed serial bits into words with valid/ack handshake
module serial_word_deserializer
  import serial_word_deserializer_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CW       = cw(WIDTH)
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             serial_in,
  input  logic             serial_valid,
  input  logic             frame_start,
  input  logic             read_ack,
  output logic [WIDTH-1:0] data_output,
  output logic             word_valid,
  output logic             overrun,
  output logic             frame_abort,
  output logic             busy,
  output logic [CW-1:0]    bit_count,
  output logic [1:0]       y_Q
);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_d;
  logic [WIDTH-1:0] sr_q, word, data_d;
  logic idle, rx, start, shift_en, done, ack, valid_d, ovr_d, abort_d;
  assign idle     = state_q == ST_IDLE;
  assign rx       = state_q == ST_RECEIVE;
  assign start    = serial_valid & frame_start & (idle | rx);
  assign shift_en = serial_valid & (rx | start);
  assign done     = rx & serial_valid & ~frame_start & (bit_count == CW'(WIDTH - 1));
  assign ack      = word_valid & read_ack;
  // the completed word includes the bit arriving on the completing edge
  assign word     = MSB_FIRST ? {sr_q[WIDTH-2:0], serial_in} : {serial_in, sr_q[WIDTH-1:1]};
  assign busy     = rx;
  assign y_Q      = state_q;
  deser_shift_register #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_sr (
    .clock(clock), .resetn(resetn), .clear(start), .shift_en(shift_en), .din(serial_in), .q(sr_q)
  );
  always_comb begin
    state_d = start ? ST_RECEIVE : (done | ~rx) ? ST_IDLE : ST_RECEIVE;
    cnt_d   = start ? CW'(1) : done ? '0 : (rx & serial_valid) ? bit_count + CW'(1) : rx ? bit_count : '0;
    data_d  = done ? word : data_output;
    valid_d = done | (word_valid & ~read_ack);
    ovr_d   = (overrun & ~ack) | (done & word_valid & ~read_ack);
    abort_d = rx & serial_valid & frame_start;
  end
  always_ff @(posedge clock)
    if (!resetn) begin
      state_q     <= ST_IDLE;
      bit_count   <= '0;
      data_output <= '0;
      word_valid  <= 1'b0;
      overrun     <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_count   <= cnt_d;
      data_output <= data_d;
      word_valid  <= valid_d;
      overrun     <= ovr_d;
      frame_abort <= abort_d;
    end
endmodule

// File: tb/tb_serial_word_deserializer.sv
// tb_serial_word_deserializer: drives MSB-first and LSB-first builds against a bit-queue model
module tb_serial_word_deserializer;
  localparam int W = 16;
  logic clk = 1'b0, rstn = 1'b0, sin = 1'b0, sv = 1'b0, fs = 1'b0, ack = 1'b0;
  logic [W-1:0] d_m, d_l;
  logic v_m, v_l, o_m, o_l, a_m, a_l, b_m, b_l;
  logic [3:0] c_m, c_l;
  logic [1:0] y_m, y_l;
  int n_checks = 0, n_fail = 0;
  bit m_inframe, m_valid, m_ovr, m_abort;
  bit m_bits[$];
  logic [W-1:0] m_data_m, m_data_l;

  always #5 clk = ~clk;

  serial_word_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
    .clock(clk), .resetn(rstn), .serial_in(sin), .serial_valid(sv), .frame_start(fs), .read_ack(ack),
    .data_output(d_m), .word_valid(v_m), .overrun(o_m), .frame_abort(a_m), .busy(b_m), .bit_count(c_m), .y_Q(y_m));
  serial_word_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clock(clk), .resetn(rstn), .serial_in(sin), .serial_valid(sv), .frame_start(fs), .read_ack(ack),
    .data_output(d_l), .word_valid(v_l), .overrun(o_l), .frame_abort(a_l), .busy(b_l), .bit_count(c_l), .y_Q(y_l));

  task automatic model_edge();
    bit done, was_valid;
    done = 0;
    was_valid = m_valid;
    if (!rstn) begin
      m_inframe = 0; m_valid = 0; m_ovr = 0; m_abort = 0; m_bits = {}; m_data_m = '0; m_data_l = '0;
      return;
    end
    m_abort = 0;
    if (sv && fs) begin
      m_abort = m_inframe;
      m_bits = {sin};
      m_inframe = 1;
    end else if (sv && m_inframe) begin
      m_bits.push_back(sin);
      if (m_bits.size() == W) begin
        done = 1;
        for (int i = 0; i < W; i++) begin
          m_data_m[W-1-i] = m_bits[i];
          m_data_l[i] = m_bits[i];
        end
        m_bits = {};
        m_inframe = 0;
      end
    end
    m_ovr = (m_ovr && !(was_valid && ack)) || (done && was_valid && !ack);
    m_valid = done || (was_valid && !ack);
  endtask

  task automatic step(input logic s_v, input logic f_s, input logic s_in, input logic a, input logic rn);
    sv = s_v; fs = f_s; sin = s_in; ack = a; rstn = rn;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic send(input logic [W-1:0] w, input logic ack_last);
    for (int i = 0; i < W; i++) step(1'b1, i == 0, w[W-1-i], ack_last && i == W - 1, 1'b1);
  endtask

  task automatic test_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if ({d_m, v_m, o_m, a_m, b_m, c_m, y_m} !== '0) begin
      n_fail++; $display("FAIL reset_msb got %h want 0", {d_m, v_m, o_m, a_m, b_m, c_m, y_m});
    end
    n_checks++;
    if ({d_l, v_l, o_l, a_l, b_l, c_l, y_l} !== '0) begin
      n_fail++; $display("FAIL reset_lsb got %h want 0", {d_l, v_l, o_l, a_l, b_l, c_l, y_l});
    end
  endtask

  task automatic test_basic();
    for (int i = 0; i < W; i++) begin
      step(1'b1, i == 0, 1'(16'hA5C3 >> (W - 1 - i)), 1'b0, 1'b1);
      if (i == 7) begin
        n_checks++;
        if (c_m !== 4'd8 || b_m !== 1'b1 || y_m !== 2'b01) begin
          n_fail++; $display("FAIL mid_frame cnt=%0d busy=%b y=%b want 8 1 01", c_m, b_m, y_m);
        end
      end
    end
    n_checks++;
    if (v_m !== 1'b1 || d_m !== 16'hA5C3 || c_m !== 4'd0) begin
      n_fail++; $display("FAIL basic_word valid=%b data=%h cnt=%0d want 1 a5c3 0", v_m, d_m, c_m);
    end
    n_checks++;
    if (d_l !== m_data_l) begin
      n_fail++; $display("FAIL basic_lsb data=%h want %h", d_l, m_data_l);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (b_m !== 1'b0 || v_m !== 1'b1) begin
      n_fail++; $display("FAIL basic_idle busy=%b valid=%b want 0 1", b_m, v_m);
    end
  endtask

  task automatic test_gap();
    logic [W-1:0] w = 16'hA5C3;
    int k = 0;
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if (v_m !== 1'b0) begin
      n_fail++; $display("FAIL ack_clear valid=%b want 0", v_m);
    end
    for (int i = 0; i < W + 3; i++) begin
      if (i >= 8 && i < 11) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      else begin
        step(1'b1, k == 0, w[W-1-k], 1'b0, 1'b1);
        k++;
      end
      if (i == W + 1) begin
        n_checks++;
        if (v_m !== 1'b0 || c_m !== 4'd15) begin
          n_fail++; $display("FAIL gap_early valid=%b cnt=%0d want 0 15", v_m, c_m);
        end
      end
    end
    n_checks++;
    if (v_m !== 1'b1 || d_m !== 16'hA5C3) begin
      n_fail++; $display("FAIL gap_word valid=%b data=%h want 1 a5c3", v_m, d_m);
    end
  endtask

  task automatic test_overrun();
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    send(16'h1234, 1'b0);
    n_checks++;
    if (o_m !== 1'b0 || d_m !== 16'h1234) begin
      n_fail++; $display("FAIL first_word overrun=%b data=%h want 0 1234", o_m, d_m);
    end
    send(16'hFFFF, 1'b0);
    n_checks++;
    if (o_m !== 1'b1 || d_m !== 16'hFFFF || v_m !== 1'b1) begin
      n_fail++; $display("FAIL overrun_set overrun=%b data=%h valid=%b want 1 ffff 1", o_m, d_m, v_m);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (o_m !== 1'b1) begin
      n_fail++; $display("FAIL overrun_sticky overrun=%b want 1", o_m);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if (o_m !== 1'b0 || v_m !== 1'b0 || d_m !== 16'hFFFF) begin
      n_fail++; $display("FAIL overrun_ack overrun=%b valid=%b data=%h want 0 0 ffff", o_m, v_m, d_m);
    end
  endtask

  task automatic test_abort();
    logic [W-1:0] w = 16'h00F0;
    int pulses = 0;
    for (int i = 0; i < 9 + W; i++) begin
      step(1'b1, i == 0 || i == 9, i < 9 ? 1'($urandom) : w[W-1-(i-9)], 1'b0, 1'b1);
      if (a_m) pulses++;
      if (i == 9) begin
        n_checks++;
        if (a_m !== 1'b1 || c_m !== 4'd1 || b_m !== 1'b1) begin
          n_fail++; $display("FAIL abort_restart abort=%b cnt=%0d busy=%b want 1 1 1", a_m, c_m, b_m);
        end
      end
    end
    n_checks++;
    if (pulses !== 1 || d_m !== 16'h00F0 || v_m !== 1'b1) begin
      n_fail++; $display("FAIL abort_word pulses=%0d data=%h valid=%b want 1 00f0 1", pulses, d_m, v_m);
    end
  endtask

  task automatic test_lsb_and_reset();
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    send(16'h8000, 1'b0);
    n_checks++;
    if (d_l !== 16'h0001 || d_m !== 16'h8000) begin
      n_fail++; $display("FAIL lsb_order lsb=%h msb=%h want 0001 8000", d_l, d_m);
    end
    for (int i = 0; i < 8; i++) step(1'b1, i == 0, 1'($urandom), 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (v_m !== 1'b0 || c_m !== 4'd0 || b_m !== 1'b0 || d_m !== 16'h0) begin
      n_fail++; $display("FAIL mid_reset valid=%b cnt=%0d busy=%b data=%h want 0 0 0 0", v_m, c_m, b_m, d_m);
    end
    send(16'hBEEF, 1'b0);
    n_checks++;
    if (d_m !== 16'hBEEF || o_m !== 1'b0 || v_m !== 1'b1 || d_l !== m_data_l) begin
      n_fail++; $display("FAIL after_reset msb=%h ovr=%b valid=%b lsb=%h want beef 0 1 %h", d_m, o_m, v_m, d_l, m_data_l);
    end
  endtask

  task automatic test_back_to_back();
    send(16'h1111, 1'b0);
    send(16'h2222, 1'b1);
    n_checks++;
    if (v_m !== 1'b1 || d_m !== 16'h2222 || o_m !== 1'b0) begin
      n_fail++; $display("FAIL ack_with_done valid=%b data=%h ovr=%b want 1 2222 0", v_m, d_m, o_m);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(9) < 7, $urandom_range(15) == 0, 1'($urandom), $urandom_range(9) < 2, $urandom_range(199) != 0);
      n_checks++;
      if ({d_m, v_m, o_m, a_m, b_m, c_m, y_m} !== {m_data_m, m_valid, m_ovr, m_abort, m_inframe, 4'(m_bits.size()), 1'b0, m_inframe}) begin
        n_fail++; $display("FAIL random_msb cycle %0d got %h want %h", n, {d_m, v_m, o_m, a_m, b_m, c_m, y_m},
          {m_data_m, m_valid, m_ovr, m_abort, m_inframe, 4'(m_bits.size()), 1'b0, m_inframe});
      end
      n_checks++;
      if ({d_l, v_l, o_l, a_l, b_l, c_l} !== {m_data_l, m_valid, m_ovr, m_abort, m_inframe, 4'(m_bits.size())}) begin
        n_fail++; $display("FAIL random_lsb cycle %0d got %h want %h", n, {d_l, v_l, o_l, a_l, b_l, c_l},
          {m_data_l, m_valid, m_ovr, m_abort, m_inframe, 4'(m_bits.size())});
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gap();
    test_overrun();
    test_abort();
    test_lsb_and_reset();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_word_deserializer.md
Name: serial_word_deserializer

Overview:
Downstream stage of the 16-to-1 serializer FSM. Receives the serial bit stream plus a frame marker and reassembles the 16-bit word. Presents the word with a valid/acknowledge handshake to the display and register path (HEX decoders, LEDs). Flags overrun when a word completes before the previous one is acknowledged, and flags frames that restart part-way through.

Parameters:
WIDTH, 16, word length in bits (>= 2)
MSB_FIRST, 1, 1 = first received bit lands in data_output[WIDTH-1]; 0 = first bit lands in data_output[0]

Ports:
clock  input  1  single system clock, rising edge
resetn  input  1  synchronous active-low reset
serial_in  input  1  serial data bit
serial_valid  input  1  serial_in is a valid bit this cycle
frame_start  input  1  qualifies the current valid bit as bit 0 of a new frame
read_ack  input  1  consumer has taken data_output
data_output  output  WIDTH  last completed word
word_valid  output  1  data_output holds an unacknowledged word
overrun  output  1  sticky: a word completed while word_valid=1 and read_ack=0
frame_abort  output  1  one-cycle pulse: frame_start arrived mid-frame
busy  output  1  high in RECEIVE
bit_count  output  clog2(WIDTH)  bits captured in the current frame
y_Q  output  2  state register, for LED debug

Behaviour:
- Reset is synchronous and active-low: on a rising clock edge with resetn=0, all outputs, the shift register and the state go to 0 (state = IDLE). Reset mid-frame discards the partial word.
- State encoding: IDLE=2'b00, RECEIVE=2'b01. Codes 2'b10 and 2'b11 are illegal and recover to IDLE on the next clock.
- Capture rule: a bit is captured only on a cycle with serial_valid=1. serial_valid=0 holds the state, count and shift register, so gaps are allowed at any point.
- IDLE, with serial_valid=1 and frame_start=1:
  - capture the bit as bit 0
  - bit_count <= 1
  - go to RECEIVE
- IDLE, with serial_valid=1 and frame_start=0: the bit is ignored.
- frame_start with serial_valid=0 is ignored in every state.
- RECEIVE, with serial_valid=1 and frame_start=0: capture the bit and increment bit_count.
- RECEIVE, with serial_valid=1 and frame_start=1:
  - frame_abort=1 for one cycle
  - the partial word is discarded
  - the current bit becomes bit 0
  - bit_count <= 1
  - stay in RECEIVE
- Completion: the WIDTH-th captured bit causes the following in the same edge:
  - the assembled word is loaded into data_output
  - word_valid <= 1
  - bit_count <= 0
  - state <= IDLE
- Latency: word_valid rises on the clock edge that captures the last bit. Back-to-back frames are allowed: a frame_start on the very next cycle is accepted from IDLE.
- Bit placement:
  - MSB_FIRST=1: shift left, and serial_in enters at the LSB.
  - MSB_FIRST=0: shift right, and serial_in enters at the MSB.
- Handshake:
  - read_ack=1 while word_valid=1 clears word_valid and overrun on the next edge.
  - data_output holds its value until the next completion.
  - read_ack with word_valid=0 has no effect.
- Completion and read_ack on the same cycle: the ack consumes the old word, the new word loads, word_valid stays 1, and overrun is not set.
- Completion with word_valid=1 and read_ack=0: the new word overwrites the old one and overrun <= 1. overrun is sticky until read_ack or reset.
- busy = (state == RECEIVE). busy is combinational from the state register.

Decomposition:
- Shared package: WIDTH default, state localparams (ST_IDLE, ST_RECEIVE), and the CW = clog2(WIDTH) counter-width function.
- Sub-module deser_shift_register. Parameters: WIDTH, MSB_FIRST. Ports: clock, resetn, clear, shift_en, din, q.
- The FSM, counter and handshake logic stay in the top module.

Test Plan:
- Reset, then frame_start+serial_valid and 16 valid bits of 0xA5C3, MSB first -> word_valid=1 and data_output=0xA5C3 on the edge of bit 16. busy is low on the following cycle.
- Same 16 bits with serial_valid dropped for 3 cycles after bit 7 -> data_output=0xA5C3 still, and completion is delayed by 3 cycles.
- Send 0x1234, hold read_ack=0, then send 0xFFFF -> data_output=0xFFFF and overrun=1. A read_ack pulse then clears both word_valid and overrun.
- Send 9 bits, then frame_start with the next bit, then 15 more bits of 0x00F0 -> frame_abort pulses once and data_output=0x00F0.
- MSB_FIRST=0 build, send bits 1,0,0,...,0 -> data_output=0x0001. Separately, send 8 bits, assert resetn=0 for one cycle, then send 16 bits of 0xBEEF -> data_output=0xBEEF with no overrun.
- Completion with read_ack=1 on the same cycle while the prior word is valid -> word_valid stays 1, the new value is present, and overrun=0.
